// File: rtl/wb_arbiter.sv
// Writeback arbiter: buffers execution-unit results in per-source FIFOs and
// drives up to WRITE_PORTS register-file writes per cycle. Sources are served
// round-robin, with at most one write per destination per cycle. Writes to
// register 0 are consumed without being issued.
//
// Ports:
//   clock, reset_n        clock, asynchronous active-low reset
//   src_valid/src_ready   per-source result handshake
//   src_addr/src_data     per-source destination register and value
//   wr_enable/wr_addr/    registered register-file write ports
//   wr_data
//   busy                  any entry buffered or any write port enabled
module wb_arbiter #(
  parameter int unsigned NUM_SRC     = 4,
  parameter int unsigned WRITE_PORTS = 2,
  parameter int unsigned ADDR_WIDTH  = 5,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned BUF_DEPTH   = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NUM_SRC-1:0]    src_valid,
  output logic [NUM_SRC-1:0]    src_ready,
  input  logic [ADDR_WIDTH-1:0] src_addr [NUM_SRC],
  input  logic [DATA_WIDTH-1:0] src_data [NUM_SRC],
  output logic [ADDR_WIDTH-1:0] wr_addr [WRITE_PORTS],
  output logic [WRITE_PORTS-1:0] wr_enable,
  output logic [DATA_WIDTH-1:0] wr_data [WRITE_PORTS],
  output logic                  busy
);

  localparam int unsigned SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int unsigned IDX_W = $clog2(BUF_DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  logic [SRC_W-1:0]      rr;
  logic [PTR_W-1:0]      wr_ptr [NUM_SRC];
  logic [PTR_W-1:0]      rd_ptr [NUM_SRC];
  logic [ADDR_WIDTH-1:0] mem_addr [NUM_SRC][BUF_DEPTH];
  logic [DATA_WIDTH-1:0] mem_data [NUM_SRC][BUF_DEPTH];

  logic [PTR_W-1:0]      count [NUM_SRC];
  logic [PTR_W-1:0]      cnt_next [NUM_SRC];
  logic [NUM_SRC-1:0]    empty;
  logic [NUM_SRC-1:0]    push;
  logic [NUM_SRC-1:0]    pop;
  logic [NUM_SRC-1:0]    ready_next;
  logic [NUM_SRC-1:0]    pending_next;
  logic [ADDR_WIDTH-1:0] head_addr [NUM_SRC];
  logic [DATA_WIDTH-1:0] head_data [NUM_SRC];

  logic [WRITE_PORTS-1:0] grant_en;
  logic [ADDR_WIDTH-1:0]  grant_addr [WRITE_PORTS];
  logic [DATA_WIDTH-1:0]  grant_data [WRITE_PORTS];
  logic                   any_grant;
  logic [SRC_W-1:0]       last_src;
  logic [SRC_W-1:0]       scan;
  logic                   conflict;
  logic                   placed;
  logic [SRC_W-1:0]       rr_next;
  logic                   busy_next;

  // FIFO occupancy, heads and accepted pushes
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      count[i]     = wr_ptr[i] - rd_ptr[i];
      empty[i]     = (count[i] == '0);
      head_addr[i] = mem_addr[i][rd_ptr[i][IDX_W-1:0]];
      head_data[i] = mem_data[i][rd_ptr[i][IDX_W-1:0]];
      push[i]      = src_valid[i] && src_ready[i];
    end
  end

  // Round-robin grant scan starting at rr; register-0 heads pop without a port
  always_comb begin
    pop       = '0;
    grant_en  = '0;
    any_grant = 1'b0;
    last_src  = '0;
    scan      = '0;
    conflict  = 1'b0;
    placed    = 1'b0;
    for (int k = 0; k < WRITE_PORTS; k++) begin
      grant_addr[k] = '0;
      grant_data[k] = '0;
    end
    for (int j = 0; j < NUM_SRC; j++) begin
      scan = SRC_W'((32'(rr) + 32'(j)) % NUM_SRC);
      if (!empty[scan]) begin
        if (head_addr[scan] == '0) begin
          pop[scan] = 1'b1;
          any_grant = 1'b1;
          last_src  = scan;
        end else begin
          conflict = 1'b0;
          placed   = 1'b0;
          for (int k = 0; k < WRITE_PORTS; k++) begin
            if (grant_en[k] && (grant_addr[k] == head_addr[scan])) conflict = 1'b1;
          end
          // ports fill in order, so the first free port is the next one
          for (int k = 0; k < WRITE_PORTS; k++) begin
            if (!conflict && !placed && !grant_en[k]) begin
              grant_en[k]   = 1'b1;
              grant_addr[k] = head_addr[scan];
              grant_data[k] = head_data[scan];
              placed        = 1'b1;
            end
          end
          if (placed) begin
            pop[scan] = 1'b1;
            any_grant = 1'b1;
            last_src  = scan;
          end
        end
      end
    end
    rr_next = any_grant ? SRC_W'((32'(last_src) + 32'd1) % NUM_SRC) : rr;
  end

  // Next-cycle occupancy drives the registered ready and busy flags
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      cnt_next[i]     = count[i] + PTR_W'(push[i]) - PTR_W'(pop[i]);
      ready_next[i]   = (cnt_next[i] < PTR_W'(BUF_DEPTH));
      pending_next[i] = (cnt_next[i] != '0);
    end
    busy_next = (|pending_next) | (|grant_en);
  end

  // Control state and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr        <= '0;
      src_ready <= '0;
      wr_enable <= '0;
      busy      <= 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
      for (int k = 0; k < WRITE_PORTS; k++) begin
        wr_addr[k] <= '0;
        wr_data[k] <= '0;
      end
    end else begin
      rr        <= rr_next;
      src_ready <= ready_next;
      wr_enable <= grant_en;
      busy      <= busy_next;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
      end
      for (int k = 0; k < WRITE_PORTS; k++) begin
        wr_addr[k] <= grant_addr[k];
        wr_data[k] <= grant_data[k];
      end
    end
  end

  // FIFO storage; validity is tracked by the pointers alone
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (push[i]) begin
        mem_addr[i][wr_ptr[i][IDX_W-1:0]] <= src_addr[i];
        mem_data[i][wr_ptr[i][IDX_W-1:0]] <= src_data[i];
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: expected register-file writes (cycle, port,
// address, data) are queued when stimulus is driven and popped as the write
// ports assert.
module tb_wb_arbiter;

  localparam int unsigned NUM_SRC     = 4;
  localparam int unsigned WRITE_PORTS = 2;
  localparam int unsigned ADDR_WIDTH  = 5;
  localparam int unsigned DATA_WIDTH  = 32;
  localparam int unsigned BUF_DEPTH   = 2;

  logic                   clock = 1'b0;
  logic                   reset_n = 1'b0;
  logic [NUM_SRC-1:0]     src_valid;
  logic [NUM_SRC-1:0]     src_ready;
  logic [ADDR_WIDTH-1:0]  src_addr [NUM_SRC];
  logic [DATA_WIDTH-1:0]  src_data [NUM_SRC];
  logic [ADDR_WIDTH-1:0]  wr_addr [WRITE_PORTS];
  logic [WRITE_PORTS-1:0] wr_enable;
  logic [DATA_WIDTH-1:0]  wr_data [WRITE_PORTS];
  logic                   busy;

  typedef struct {
    int                    cyc;
    int                    port;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } wr_exp_t;

  wr_exp_t exp_q[$];
  int cyc     = 0;
  int n_pass  = 0;
  int n_total = 0;
  int b       = 0;

  // backpressure stimulus: per cycle, address driven by each source (-1 = idle)
  int bp_tab [4][NUM_SRC] = '{'{10, 13, 16, 19}, '{11, 14, 17, 20},
                              '{12, 15, 18, 21}, '{12, 15, -1, -1}};
  logic [NUM_SRC-1:0] bp_ready [5] = '{4'b1111, 4'b1100, 4'b0011, 4'b1100, 4'b1111};

  wb_arbiter #(
    .NUM_SRC(NUM_SRC), .WRITE_PORTS(WRITE_PORTS), .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH), .BUF_DEPTH(BUF_DEPTH)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .src_valid(src_valid), .src_ready(src_ready),
    .src_addr(src_addr), .src_data(src_data),
    .wr_addr(wr_addr), .wr_enable(wr_enable), .wr_data(wr_data),
    .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic expect_wr(input int c, input int p, input int a, input logic [31:0] d);
    wr_exp_t e;
    e.cyc  = c;
    e.port = p;
    e.addr = ADDR_WIDTH'(a);
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic drive(input int s, input int a, input logic [31:0] d);
    src_valid[s] = 1'b1;
    src_addr[s]  = ADDR_WIDTH'(a);
    src_data[s]  = d;
  endtask

  task automatic idle();
    src_valid = '0;
  endtask

  // advance one clock, then score every write port against the queue
  task automatic step();
    wr_exp_t e;
    @(posedge clock);
    #1;
    cyc++;
    for (int k = 0; k < WRITE_PORTS; k++) begin
      if (wr_enable[k]) begin
        check("wr_addr_nonzero", 64'(wr_addr[k] == '0), 64'(0));
        for (int m = k + 1; m < WRITE_PORTS; m++)
          if (wr_enable[m]) check("wr_addr_unique", 64'(wr_addr[k] == wr_addr[m]), 64'(0));
        if (exp_q.size() == 0) begin
          check("spurious_wr_enable", 64'(wr_enable[k]), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("wr_cycle", 64'(cyc), 64'(e.cyc));
          check("wr_port", 64'(k), 64'(e.port));
          check("wr_addr", 64'(wr_addr[k]), 64'(e.addr));
          check("wr_data", 64'(wr_data[k]), 64'(e.data));
        end
      end else begin
        check("idle_wr_addr", 64'(wr_addr[k]), 64'(0));
        check("idle_wr_data", 64'(wr_data[k]), 64'(0));
      end
    end
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      check("overdue_write", 64'(wr_enable[e.port] && (wr_addr[e.port] == e.addr)), 64'(1));
    end
  endtask

  initial begin
    src_valid = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_addr[i] = '0;
      src_data[i] = '0;
    end

    // reset and idle
    #12;
    check("rst_wr_enable", 64'(wr_enable), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_src_ready", 64'(src_ready), 64'(0));
    @(negedge clock);
    reset_n = 1'b1;
    step();
    check("idle_src_ready", 64'(src_ready), 64'hF);
    check("idle_busy", 64'(busy), 64'(0));
    check("idle_wr_enable", 64'(wr_enable), 64'(0));

    // port exhaustion and round-robin, rr = 0
    b = cyc;
    drive(0, 1, 32'hA1); drive(1, 2, 32'hA2); drive(2, 3, 32'hA3); drive(3, 4, 32'hA4);
    expect_wr(b + 2, 0, 1, 32'hA1); expect_wr(b + 2, 1, 2, 32'hA2);
    expect_wr(b + 3, 0, 3, 32'hA3); expect_wr(b + 3, 1, 4, 32'hA4);
    step(); idle();
    check("exh_busy_buffered", 64'(busy), 64'(1));
    step(); step(); step();
    check("exh_busy_done", 64'(busy), 64'(0));
    check("exh_queue_drained", 64'(exp_q.size()), 64'(0));

    // same-address conflict, rr back at 0
    b = cyc;
    drive(0, 7, 32'h11); drive(2, 7, 32'h22);
    expect_wr(b + 2, 0, 7, 32'h11);
    expect_wr(b + 3, 0, 7, 32'h22);
    step(); idle();
    step(); step(); step();
    check("conf_queue_drained", 64'(exp_q.size()), 64'(0));

    // register 0 is consumed without a write
    b = cyc;
    drive(3, 0, 32'hFF); drive(0, 9, 32'h99);
    expect_wr(b + 2, 0, 9, 32'h99);
    step(); idle();
    step();
    check("r0_busy_writing", 64'(busy), 64'(1));
    step();
    check("r0_busy_empty", 64'(busy), 64'(0));
    check("r0_src_ready", 64'(src_ready), 64'hF);

    // single source, one-cycle write pulse
    b = cyc;
    drive(1, 5, 32'hDEADBEEF);
    expect_wr(b + 2, 0, 5, 32'hDEADBEEF);
    step(); idle();
    check("single_not_yet", 64'(wr_enable), 64'(0));
    step();
    check("single_wr_enable", 64'(wr_enable), 64'b01);
    step();
    check("single_wr_enable_off", 64'(wr_enable), 64'(0));
    check("single_busy_off", 64'(busy), 64'(0));

    // backpressure on src0 with the ports saturated
    b = cyc;
    expect_wr(b + 2, 0, 16, 32'hB000_0010); expect_wr(b + 2, 1, 19, 32'hB000_0013);
    expect_wr(b + 3, 0, 10, 32'hB000_000A); expect_wr(b + 3, 1, 13, 32'hB000_000D);
    expect_wr(b + 4, 0, 17, 32'hB000_0011); expect_wr(b + 4, 1, 20, 32'hB000_0014);
    expect_wr(b + 5, 0, 11, 32'hB000_000B); expect_wr(b + 5, 1, 14, 32'hB000_000E);
    expect_wr(b + 6, 0, 18, 32'hB000_0012); expect_wr(b + 6, 1, 21, 32'hB000_0015);
    expect_wr(b + 7, 0, 12, 32'hB000_000C); expect_wr(b + 7, 1, 15, 32'hB000_000F);
    for (int t = 0; t < 4; t++) begin
      idle();
      for (int s = 0; s < NUM_SRC; s++)
        if (bp_tab[t][s] >= 0) drive(s, bp_tab[t][s], 32'hB000_0000 | 32'(bp_tab[t][s]));
      step();
      check("bp_src_ready", 64'(src_ready), 64'(bp_ready[t]));
    end
    idle();
    step();
    check("bp_src_ready_final", 64'(src_ready), 64'(bp_ready[4]));
    step(); step(); step();
    check("bp_busy_done", 64'(busy), 64'(0));
    check("bp_queue_drained", 64'(exp_q.size()), 64'(0));

    // reset mid-burst with three entries buffered and writes in flight
    b = cyc;
    drive(0, 25, 32'hC0); drive(1, 26, 32'hC1); drive(2, 27, 32'hC2); drive(3, 28, 32'hC3);
    expect_wr(b + 2, 0, 27, 32'hC2); expect_wr(b + 2, 1, 28, 32'hC3);
    step(); idle();
    drive(2, 29, 32'hC4);
    step(); idle();
    check("mid_wr_enable_live", 64'(wr_enable), 64'b11);
    reset_n = 1'b0;
    #1;
    check("mid_rst_wr_enable", 64'(wr_enable), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_src_ready", 64'(src_ready), 64'(0));
    check("mid_rst_wr_addr0", 64'(wr_addr[0]), 64'(0));
    check("mid_rst_wr_data1", 64'(wr_data[1]), 64'(0));
    step(); step();
    reset_n = 1'b1;
    step();
    check("post_rst_src_ready", 64'(src_ready), 64'hF);
    check("post_rst_busy", 64'(busy), 64'(0));
    step(); step(); step();
    check("post_rst_no_write", 64'(wr_enable), 64'(0));
    check("post_rst_busy_late", 64'(busy), 64'(0));
    check("final_queue_drained", 64'(exp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
Writeback arbiter and the producer side of the multi-ported register file write interface. It collects results from NUM_SRC execution units over valid/ready handshakes and buffers them per source. Each cycle it drives up to WRITE_PORTS register-file writes through registered wr_addr/wr_enable/wr_data ports. It enforces round-robin fairness, at most one write per destination register per cycle, and no architectural write to register 0.

Parameters:
NUM_SRC, 4, number of result sources (execution units)
WRITE_PORTS, 2, number of register file write ports driven
ADDR_WIDTH, 5, register address width
DATA_WIDTH, 32, register data width
BUF_DEPTH, 2, per-source FIFO depth; power of two, >=2

Ports:
clock  in  1  clock
reset_n  in  1  asynchronous reset, active-low
src_valid[NUM_SRC]  in  1  source i presents a result
src_ready[NUM_SRC]  out  1  source i FIFO can accept
src_addr[NUM_SRC]  in  ADDR_WIDTH  destination register of source i
src_data[NUM_SRC]  in  DATA_WIDTH  result value of source i
wr_addr[WRITE_PORTS]  out  ADDR_WIDTH  register file write address, port k
wr_enable[WRITE_PORTS]  out  1  register file write enable, port k
wr_data[WRITE_PORTS]  out  DATA_WIDTH  register file write data, port k
busy  out  1  any entry buffered or any wr_enable high

Behaviour:
- Reset: the reset is asynchronous and active-low on reset_n, and the block is clocked on clock. While reset is asserted:
  - all FIFOs are emptied; buffered entries are discarded, including on a reset mid-operation.
  - rr pointer is set to 0.
  - wr_enable, wr_addr and wr_data are all 0, and busy is 0.
  - src_ready is forced to 0.
- Accept: a push into FIFO i happens at a posedge where src_valid[i] && src_ready[i].
  - src_ready[i] = (count_i < BUF_DEPTH). It depends on registered state only, with no combinational path from src_valid or from grants.
  - A full FIFO does not accept, even if its head is popped in the same cycle.
  - There is no bypass: a pushed entry is first eligible for grant in the following cycle.
- Per-source ordering: only the head of each FIFO is a candidate. Entries from one source are written strictly in acceptance order.
- Grant scan, combinational each cycle: visit sources rr, rr+1, ..., rr+NUM_SRC-1 (mod NUM_SRC). For each non-empty head:
  - addr == 0: granted (popped); no write port used; no write issued.
  - addr != 0, ports used < WRITE_PORTS, and addr not equal to an address already granted this cycle: granted, assigned the next free port k in scan order.
  - otherwise: deferred, stays at head.
- Output register update at posedge:
  - For each granted k: wr_enable[k] <= 1, wr_addr[k] <= addr, wr_data[k] <= data.
  - Unused ports: wr_enable <= 0, wr_addr <= 0, wr_data <= 0.
  - Granted heads are popped at the same edge.
- Latency:
  - An entry accepted at edge N with no contention appears on wr_* after edge N+1.
  - The register file captures it at edge N+2.
- rr update:
  - If any grant occurred (including addr 0), rr <= (index of last granted source + 1) mod NUM_SRC.
  - Otherwise rr holds.
  - This guarantees a deferred source is scanned first within NUM_SRC cycles, so there is no starvation.
- Invariant: no two asserted wr_enable ports ever carry the same wr_addr. wr_addr is never 0 while enabled.
- busy is combinational from registered state: OR of all FIFO non-empty flags and all wr_enable bits.
- Counts use ADDR-independent pointers of log2(BUF_DEPTH)+1 bits with natural wrap. Full when count == BUF_DEPTH; empty when 0.

Test Plan:
- Reset then idle:
  - All wr_enable are 0, src_ready all 1 after release, busy 0.
  - Assert reset_n low mid-burst with 3 entries buffered: outputs clear immediately, and no write appears after release.
- Single source:
  - src 1 pushes addr 5 / data 0xDEADBEEF at edge N.
  - After edge N+1, expect wr_enable[0]=1, wr_addr[0]=5, wr_data[0]=0xDEADBEEF for exactly one cycle, then wr_enable[0]=0.
- Port exhaustion and round-robin:
  - All 4 sources push addrs 1,2,3,4 simultaneously with rr=0.
  - Cycle 1 writes addrs 1,2 on ports 0,1; cycle 2 writes addrs 3,4; rr ends at 0.
- Same-address conflict:
  - src0 and src2 push addr 7 (data 0x11, 0x22) together with rr=0.
  - First write cycle: only 0x11 on port 0. Next cycle: 0x22 with addr 7.
  - The two writes are never in the same cycle.
- Register 0 suppression:
  - src3 pushes addr 0 / data 0xFF, and src0 pushes addr 9 in the same cycle.
  - Only addr 9 is written, on port 0; the src3 FIFO empties; no wr_enable with wr_addr 0.
- Backpressure:
  - src0 pushes 3 consecutive cycles while other sources keep ports saturated.
  - src_ready[0] drops after 2 accepts. The third result is held by the source until ready returns.
  - Writes from src0 emerge in push order.
